// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, sizes, sigma shift/rotate amounts and the shr/rotr primitives.
package sha256_pkg;

    localparam int WORD_W     = 32;
    localparam int NUM_ROUNDS = 64;
    localparam int BLOCK_W    = 512;
    localparam int WIN_DEPTH  = 16;

    localparam int unsigned S0_ROT_A = 7;
    localparam int unsigned S0_ROT_B = 18;
    localparam int unsigned S0_SHR   = 3;
    localparam int unsigned S1_ROT_A = 17;
    localparam int unsigned S1_ROT_B = 19;
    localparam int unsigned S1_SHR   = 10;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic word_t shr(input word_t x, input int unsigned n);
        return x >> n;
    endfunction

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage

// File: rtl/sha256_sigma.sv
// Combinational SHA-256 small sigma: ROTR(a) ^ ROTR(b) ^ (SHR or ROTR)(c).
module sha256_sigma
    import sha256_pkg::*;
#(
    parameter int unsigned ROT_A       = 7,
    parameter int unsigned ROT_B       = 18,
    parameter int unsigned LAST_AMT    = 3,
    parameter bit          LAST_IS_SHR = 1'b1
) (
    input  word_t x_i,
    output word_t y_o
);

    word_t last_term;

    assign last_term = LAST_IS_SHR ? shr(x_i, LAST_AMT) : rotr(x_i, LAST_AMT);
    assign y_o       = rotr(x_i, ROT_A) ^ rotr(x_i, ROT_B) ^ last_term;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander: one 512-bit block in, W[0..63] out over a valid/ready stream.
// Optional macro SHA_SCHED_TIDX_EN adds the t_idx output (registered round index).
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic [BLOCK_W-1:0] blk_data,
    output logic               w_valid,
    input  logic               w_ready,
    output logic [WORD_W-1:0]  w_data,
    output logic               w_last
`ifdef SHA_SCHED_TIDX_EN
    ,
    output logic [5:0]         t_idx
`endif
);

    localparam logic [5:0] T_LAST = 6'(NUM_ROUNDS - 1);

    state_e     state_q, state_d;
    word_t      win_q [WIN_DEPTH];
    word_t      win_d [WIN_DEPTH];
    logic [5:0] t_q, t_d;
    logic       blk_ready_q, blk_ready_d;
    logic       w_valid_q, w_valid_d;
    logic       w_last_q, w_last_d;
    word_t      s0_w, s1_w, w_next;

    sha256_sigma #(
        .ROT_A(S0_ROT_A), .ROT_B(S0_ROT_B), .LAST_AMT(S0_SHR), .LAST_IS_SHR(1'b1)
    ) u_sigma0 (
        .x_i(win_q[1]),
        .y_o(s0_w)
    );

    sha256_sigma #(
        .ROT_A(S1_ROT_A), .ROT_B(S1_ROT_B), .LAST_AMT(S1_SHR), .LAST_IS_SHR(1'b1)
    ) u_sigma1 (
        .x_i(win_q[14]),
        .y_o(s1_w)
    );

    // W[t+16] from the window holding W[t..t+15]; the carry out of bit 31 is dropped.
    assign w_next = s1_w + win_q[9] + s0_w + win_q[0];

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        state_d = state_q;
        win_d   = win_q;
        t_d     = t_q;
        unique case (state_q)
            IDLE: begin
                if (blk_valid && blk_ready_q) begin
                    for (int i = 0; i < WIN_DEPTH; i++) begin
                        win_d[i] = blk_data[BLOCK_W-1-WORD_W*i -: WORD_W];
                    end
                    t_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (w_valid_q && w_ready) begin
                    for (int i = 0; i < WIN_DEPTH - 1; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[WIN_DEPTH-1] = w_next;
                    if (t_q == T_LAST) begin
                        t_d     = '0;
                        state_d = IDLE;
                    end else begin
                        t_d = t_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake outputs are registered copies of the next state, so they carry no input path.
        blk_ready_d = (state_d == IDLE);
        w_valid_d   = (state_d == RUN);
        w_last_d    = (state_d == RUN) && (t_d == T_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            t_q         <= '0;
            blk_ready_q <= 1'b0;
            w_valid_q   <= 1'b0;
            w_last_q    <= 1'b0;
            // NOTE: the window is reset too, because w_data is driven straight from win_q[0].
            for (int i = 0; i < WIN_DEPTH; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            blk_ready_q <= blk_ready_d;
            w_valid_q   <= w_valid_d;
            w_last_q    <= w_last_d;
            win_q       <= win_d;
        end
    end

    assign blk_ready = blk_ready_q;
    assign w_valid   = w_valid_q;
    assign w_last    = w_last_q;
    assign w_data    = win_q[0];

`ifdef SHA_SCHED_TIDX_EN
    assign t_idx = t_q;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule against a direct W[t] recurrence model.
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_data;
    logic         w_last;
`ifdef SHA_SCHED_TIDX_EN
    logic [5:0]   t_idx;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [31:0] exp_w [64];
    logic [31:0] got_w [64];

    sha256_msg_schedule dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .blk_valid(blk_valid),
        .blk_ready(blk_ready),
        .blk_data (blk_data),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_data   (w_data),
        .w_last   (w_last)
`ifdef SHA_SCHED_TIDX_EN
        ,
        .t_idx    (t_idx)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
        logic [63:0] xx;
        xx = {x, x} >> n;
        return xx[31:0];
    endfunction

    function automatic logic [31:0] m_s0(input logic [31:0] x);
        return m_rotr(x, 7) ^ m_rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] m_s1(input logic [31:0] x);
        return m_rotr(x, 17) ^ m_rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic void build_model(input logic [511:0] blk);
        for (int t = 0; t < 16; t++) exp_w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            exp_w[t] = m_s1(exp_w[t-2]) + exp_w[t-7] + m_s0(exp_w[t-15]) + exp_w[t-16];
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // Offer one block and consume its words; called at a negedge, returns at a negedge.
    task automatic do_block(input logic [511:0] blk, input bit stall_mode, input int abort_at,
                            input bit has_next, input logic [511:0] next_blk, output int first_cyc);
        int  beat, waited, stall_left, budget;
        bit  forced;
        build_model(blk);
        first_cyc = -1;
        blk_data  = blk;
        blk_valid = 1'b1;
        waited    = 0;
        while (!blk_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!blk_ready) begin
            check("blk_accept_timeout", 32'(blk_ready), 32'd1);
            blk_valid = 1'b0;
            return;
        end
        @(negedge clk);
        blk_valid = has_next;
        if (has_next) blk_data = next_blk;
        first_cyc = cyc;
        check("latency_w_valid", 32'(w_valid), 32'd1);
        check("blk_ready_in_run", 32'(blk_ready), 32'd0);
        beat = 0; stall_left = 0; budget = 0; forced = 1'b0;
        while (beat < 64 && budget < 5000) begin
            if (beat == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("abort_w_valid", 32'(w_valid), 32'd0);
                check("abort_w_data", w_data, 32'd0);
                check("abort_w_last", 32'(w_last), 32'd0);
                check("abort_blk_ready", 32'(blk_ready), 32'd0);
                blk_valid = 1'b0;
                w_ready   = 1'b0;
                return;
            end
            if (!stall_mode) begin
                w_ready = 1'b1;
            end else if (stall_left > 0) begin
                w_ready = 1'b0;
                stall_left--;
            end else if ((beat == 10 && !forced) || $urandom_range(15) == 0) begin
                forced     = 1'b1;
                stall_left = $urandom_range(30, 20);
                w_ready    = 1'b0;
            end else begin
                w_ready = 1'($urandom_range(1));
            end
            if (w_valid) begin
                check("w_data", w_data, exp_w[beat]);
                if (w_ready) begin
                    check("w_last", 32'(w_last), 32'(beat == 63));
`ifdef SHA_SCHED_TIDX_EN
                    check("t_idx", 32'(t_idx), 32'(beat));
`endif
                    got_w[beat] = w_data;
                    beat++;
                end
            end else begin
                check("w_valid_dropped", 32'(w_valid), 32'd1);
            end
            @(negedge clk);
            budget++;
        end
        if (beat < 64) check("stream_timeout", 32'(beat), 32'd64);
        w_ready = 1'b0;
        check("idle_w_valid", 32'(w_valid), 32'd0);
        check("idle_w_last", 32'(w_last), 32'd0);
        check("idle_blk_ready", 32'(blk_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] abc, ones, blk_a, blk_b;
        int c_a, c_b, c_x;
        abc  = {32'h61626380, 448'b0, 32'h00000018};
        ones = '1;

        // Reset and idle
        rst_n = 1'b0; blk_valid = 1'b0; w_ready = 1'b0; blk_data = '0;
        repeat (3) @(negedge clk);
        check("rst_blk_ready", 32'(blk_ready), 32'd0);
        check("rst_w_valid", 32'(w_valid), 32'd0);
        check("rst_w_data", w_data, 32'd0);
        check("rst_w_last", 32'(w_last), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_blk_ready", 32'(blk_ready), 32'd1);
        check("post_rst_w_valid", 32'(w_valid), 32'd0);
        check("post_rst_w_data", w_data, 32'd0);

        // "abc" block, free-flowing
        do_block(abc, 1'b0, -1, 1'b0, '0, c_x);
        check("abc_w0", got_w[0], 32'h61626380);
        check("abc_w15", got_w[15], 32'h00000018);
        check("abc_w16", got_w[16], 32'h61626380);
        check("abc_w17", got_w[17], 32'h000F0000);

        // Same block with backpressure
        do_block(abc, 1'b1, -1, 1'b0, '0, c_x);
        check("abc_bp_w17", got_w[17], 32'h000F0000);

        // Back-to-back blocks
        blk_a = rand_block();
        blk_b = rand_block();
        do_block(blk_a, 1'b0, -1, 1'b1, blk_b, c_a);
        do_block(blk_b, 1'b0, -1, 1'b0, '0, c_b);
        check("b2b_spacing", 32'(c_b - c_a), 32'd65);
        check("b2b_second_w0", got_w[0], blk_b[511:480]);

        // Mid-block reset, then clean restart
        do_block(rand_block(), 1'b0, 30, 1'b0, '0, c_x);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_blk_ready", 32'(blk_ready), 32'd1);
        blk_a = rand_block();
        do_block(blk_a, 1'b0, -1, 1'b0, '0, c_x);
        check("restart_w0", got_w[0], blk_a[511:480]);

        // All-ones block exercises dropped carries
        do_block(ones, 1'b1, -1, 1'b0, '0, c_x);

        // Random blocks with random stalls
        for (int k = 0; k < 3; k++) do_block(rand_block(), 1'b1, -1, 1'b0, '0, c_x);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
